// File: rtl/pea_out_sel_seq_pkg.sv
// Shared sizes, types and helpers for the PEA output-selector context sequencer.
package pea_out_sel_seq_pkg;

  localparam int N           = 2;
  localparam int N_OUT_PEA   = N * 2;
  localparam int LOG_M       = 3;
  localparam int KMEM_SIZE   = 4;
  localparam int SEL_BITS    = KMEM_SIZE * N_OUT_PEA * LOG_M;
  localparam int N_CFG_WORDS = (SEL_BITS + 31) / 32;
  localparam int LOG_KMEM    = (KMEM_SIZE > 1) ? $clog2(KMEM_SIZE) : 1;
  localparam int CFG_ADDR_W  = $clog2(N_CFG_WORDS) + 1;
  localparam int STORE_W     = N_CFG_WORDS * 32;
  localparam int NCTX_W      = LOG_KMEM + 1;

  typedef logic [LOG_M-1:0] pea_out_sel_t;
  typedef pea_out_sel_t [N_OUT_PEA-1:0] pea_out_sel_vec_t;
  typedef enum logic {SEQ_IDLE = 1'b0, SEQ_RUN = 1'b1} pea_out_seq_state_e;

  // Context i, output j lives at bits [(i*N_OUT_PEA+j)*LOG_M +: LOG_M] of the store.
  function automatic pea_out_sel_vec_t pick_ctx(input logic [STORE_W-1:0] store,
                                                input logic [LOG_KMEM-1:0] ctx);
    pea_out_sel_vec_t v;
    for (int j = 0; j < N_OUT_PEA; j++) begin
      v[j] = store[(int'(ctx) * N_OUT_PEA + j) * LOG_M +: LOG_M];
    end
    return v;
  endfunction

  function automatic logic [NCTX_W-1:0] eff_n_ctx(input logic [NCTX_W-1:0] n);
    if (n == NCTX_W'(0)) begin
      return NCTX_W'(1);
    end else if (n > NCTX_W'(KMEM_SIZE)) begin
      return NCTX_W'(KMEM_SIZE);
    end else begin
      return n;
    end
  endfunction

  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/pea_out_sel_seq_if.sv
// Config-word write bus into the selector store, with the reject pulse back to the host.
interface pea_out_sel_seq_if;
  import pea_out_sel_seq_pkg::*;

  logic                  cfg_we_i;
  logic [CFG_ADDR_W-1:0] cfg_addr_i;
  logic [31:0]           cfg_wdata_i;
  logic                  cfg_err_o;

  modport master (output cfg_we_i, output cfg_addr_i, output cfg_wdata_i, input cfg_err_o);
  modport slave  (input cfg_we_i, input cfg_addr_i, input cfg_wdata_i, output cfg_err_o);
endinterface

// File: rtl/pea_out_sel_seq_ctx_ctr.sv
// Period counter feeding a wrapping context counter; exposes both the registered and next context.
module pea_out_sel_ctx_ctr
  import pea_out_sel_seq_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [15:0]         period_i,
  input  logic [NCTX_W-1:0]   n_ctx_i,
  output logic [LOG_KMEM-1:0] ctx_o,
  output logic [LOG_KMEM-1:0] ctx_nxt_o,
  output logic                wrap_o,
  output logic                wrap_nxt_o
);

  logic [15:0]         cnt_q, cnt_d;
  logic [LOG_KMEM-1:0] ctx_q, ctx_d;
  logic                wrap_q, wrap_d;

  // Next count/context; clear dominates, a stalled cycle holds everything.
  always_comb begin
    cnt_d  = cnt_q;
    ctx_d  = ctx_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = 16'd0;
      ctx_d = '0;
    end else if (en_i) begin
      if (cnt_q == period_i - 16'd1) begin
        cnt_d = 16'd0;
        if (NCTX_W'(ctx_q) == n_ctx_i - NCTX_W'(1)) begin
          ctx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ctx_d = ctx_q + LOG_KMEM'(1);
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 16'd0;
      ctx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ctx_q  <= ctx_d;
      wrap_q <= wrap_d;
    end
  end

  assign ctx_o      = ctx_q;
  assign ctx_nxt_o  = ctx_d;
  assign wrap_o     = wrap_q;
  assign wrap_nxt_o = wrap_d;

endmodule

// File: rtl/pea_out_sel_seq.sv
// PEA output-selector store and context sequencer.
// PEA_OUT_SEL_SHADOW_EN: writes land in a shadow store copied to the active one in IDLE or at each wrap.
module pea_out_sel_seq
  import pea_out_sel_seq_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  pea_out_sel_seq_if.slave        cfg,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    stall_i,
  input  logic [NCTX_W-1:0]       n_ctx_i,
  input  logic [15:0]             ctx_period_i,
  output pea_out_sel_vec_t        sel_output_o,
  output logic [LOG_KMEM-1:0]     ctx_idx_o,
  output logic                    busy_o,
  output logic                    ctx_wrap_o
);

  pea_out_seq_state_e  state_q;
  logic [STORE_W-1:0]  active_q, active_d;
  pea_out_sel_vec_t    sel_q;
  logic                busy_q, err_q, err_d;
  logic [15:0]         period_q;
  logic [NCTX_W-1:0]   n_ctx_q;
  logic                run_s, in_range_s, wr_ok_s, ctr_clr_s, ctr_en_s, wrap_nxt_s;
  logic [LOG_KMEM-1:0] ctx_nxt_s;
  logic [STORE_W-1:0]  wr_base_s, wr_store_s;

  // Control decode shared by the store and the counter.
  always_comb begin
    run_s      = (state_q == SEQ_RUN);
    in_range_s = (cfg.cfg_addr_i < CFG_ADDR_W'(N_CFG_WORDS));
    wr_ok_s    = cfg.cfg_we_i && in_range_s;
    ctr_clr_s  = !run_s || stop_i;
    ctr_en_s   = run_s && !stall_i;
  end

  // Merge the incoming config word into whichever store receives writes.
  always_comb begin
    wr_store_s = wr_base_s;
    for (int k = 0; k < N_CFG_WORDS; k++) begin
      wr_store_s[32*k +: 32] = (wr_ok_s && (cfg.cfg_addr_i == CFG_ADDR_W'(k)))
                               ? cfg.cfg_wdata_i : wr_base_s[32*k +: 32];
    end
  end

`ifdef PEA_OUT_SEL_SHADOW_EN
  logic [STORE_W-1:0] shadow_q;

  // Active store follows the shadow in IDLE and only refreshes on a wrap in RUN.
  always_comb begin
    wr_base_s = shadow_q;
    err_d     = cfg.cfg_we_i && !in_range_s;
    if (!run_s || wrap_nxt_s) begin
      active_d = wr_store_s;
    end else begin
      active_d = active_q;
    end
  end

  // Shadow store register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= wr_store_s;
    end
  end
`else
  // Single store: writes only take effect while IDLE.
  always_comb begin
    wr_base_s = active_q;
    err_d     = cfg.cfg_we_i && (!in_range_s || run_s);
    if (run_s) begin
      active_d = active_q;
    end else begin
      active_d = wr_store_s;
    end
  end
`endif

  pea_out_sel_ctx_ctr u_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (ctr_clr_s),
    .en_i       (ctr_en_s),
    .period_i   (period_q),
    .n_ctx_i    (n_ctx_q),
    .ctx_o      (ctx_idx_o),
    .ctx_nxt_o  (ctx_nxt_s),
    .wrap_o     (ctx_wrap_o),
    .wrap_nxt_o (wrap_nxt_s)
  );

  // Sequencer FSM, store and selector registers; selectors use the same next context as ctx_idx_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEQ_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      active_q <= '0;
      period_q <= 16'd1;
      n_ctx_q  <= NCTX_W'(1);
    end else begin
      active_q <= active_d;
      err_q    <= err_d;
      sel_q    <= pick_ctx(active_d, ctx_nxt_s);
      case (state_q)
        SEQ_IDLE: begin
          if (start_i && !stop_i) begin
            state_q  <= SEQ_RUN;
            busy_q   <= 1'b1;
            period_q <= eff_period(ctx_period_i);
            n_ctx_q  <= eff_n_ctx(n_ctx_i);
          end else begin
            busy_q <= 1'b0;
          end
        end
        SEQ_RUN: begin
          if (stop_i) begin
            state_q <= SEQ_IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_output_o  = sel_q;
  assign busy_o        = busy_q;
  assign cfg.cfg_err_o = err_q;

endmodule

// File: tb/tb_pea_out_sel_seq.sv
// Directed + randomized bench for pea_out_sel_seq against a cycle-count model of the sequencer.
module tb_pea_out_sel_seq;
  import pea_out_sel_seq_pkg::*;

`ifdef PEA_OUT_SEL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, start, stop, stall;
  logic [NCTX_W-1:0]   n_ctx;
  logic [15:0]         period;
  pea_out_sel_vec_t    sel;
  logic [LOG_KMEM-1:0] ctx_idx;
  logic                busy, wrap;

  pea_out_sel_seq_if cfg_if ();

  always #5 clk = ~clk;

  pea_out_sel_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg          (cfg_if),
    .start_i      (start),
    .stop_i       (stop),
    .stall_i      (stall),
    .n_ctx_i      (n_ctx),
    .ctx_period_i (period),
    .sel_output_o (sel),
    .ctx_idx_o    (ctx_idx),
    .busy_o       (busy),
    .ctx_wrap_o   (wrap)
  );

  // Model: word arrays, run flag, and count of non-stalled RUN edges since start.
  logic [31:0] m_act [N_CFG_WORDS];
  logic [31:0] m_shd [N_CFG_WORDS];
  bit m_run, m_wrap, m_err;
  int m_e, m_p, m_n;
  int total = 0;
  int passed = 0;

  function automatic pea_out_sel_vec_t exp_sel(input int ctx);
    logic [STORE_W-1:0] flat;
    pea_out_sel_vec_t v;
    for (int k = 0; k < N_CFG_WORDS; k++) flat[32*k +: 32] = m_act[k];
    for (int j = 0; j < N_OUT_PEA; j++) v[j] = flat[(ctx * N_OUT_PEA + j) * LOG_M +: LOG_M];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    bit was_run;
    int a, exp_ctx;
    @(posedge clk);
    was_run = m_run;
    m_wrap  = 1'b0;
    a       = int'(cfg_if.cfg_addr_i);
    if (rst) begin
      for (int k = 0; k < N_CFG_WORDS; k++) begin
        m_act[k] = 32'd0;
        m_shd[k] = 32'd0;
      end
      m_run = 1'b0; m_err = 1'b0; m_e = 0;
    end else begin
      m_err = cfg_if.cfg_we_i && (a >= N_CFG_WORDS || (!SHADOW && was_run));
      if (cfg_if.cfg_we_i && a < N_CFG_WORDS) begin
        if (SHADOW) m_shd[a] = cfg_if.cfg_wdata_i;
        else if (!was_run) m_act[a] = cfg_if.cfg_wdata_i;
      end
      if (was_run) begin
        if (stop) begin
          m_run = 1'b0;
        end else if (!stall) begin
          m_e++;
          if (m_e % (m_p * m_n) == 0) begin
            m_wrap = 1'b1;
            if (SHADOW) m_act = m_shd;
          end
        end
      end else begin
        if (SHADOW) m_act = m_shd;
        if (start && !stop) begin
          m_run = 1'b1;
          m_e   = 0;
          m_p   = (period == 16'd0) ? 1 : int'(period);
          m_n   = (n_ctx == '0) ? 1 : ((int'(n_ctx) > KMEM_SIZE) ? KMEM_SIZE : int'(n_ctx));
        end
      end
    end
    #1;
    exp_ctx = m_run ? (m_e / m_p) % m_n : 0;
    check("busy", 64'(busy), 64'(m_run));
    check("ctx_idx", 64'(ctx_idx), 64'(exp_ctx));
    check("ctx_wrap", 64'(wrap), 64'(m_wrap));
    check("cfg_err", 64'(cfg_if.cfg_err_o), 64'(m_err));
    check("sel_output", 64'(sel), 64'(exp_sel(exp_ctx)));
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    cfg_if.cfg_we_i    = 1'b1;
    cfg_if.cfg_addr_i  = CFG_ADDR_W'(addr);
    cfg_if.cfg_wdata_i = data;
    tick();
    cfg_if.cfg_we_i = 1'b0;
  endtask

  task automatic go(input int n, input int p);
    n_ctx  = NCTX_W'(n);
    period = 16'(p);
    start  = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; stall = 1'b0;
    n_ctx = '0; period = 16'd0;
    cfg_if.cfg_we_i = 1'b0; cfg_if.cfg_addr_i = '0; cfg_if.cfg_wdata_i = 32'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // All-ones context 0 visible one cycle after the write.
    write_word(0, 32'hFFFF_FFFF);
    tick();

    // Distinct contexts, n_ctx=3, period=4: two full loops.
    for (int k = 0; k < N_CFG_WORDS; k++) write_word(k, $urandom);
    go(3, 4);
    repeat (30) tick();

    // start+stop together in RUN: stop wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();

    // Out-of-range writes are rejected.
    write_word(N_CFG_WORDS, $urandom);
    tick();
    write_word((1 << CFG_ADDR_W) - 1, $urandom);
    tick();

    // period=0, n_ctx=0 behave as 1/1.
    go(0, 0);
    repeat (6) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // Write context 0 during RUN with n_ctx=2, period=3.
    go(2, 3);
    repeat (2) tick();
    write_word(0, $urandom);
    repeat (10) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();

    // Five-cycle stall mid-context, then stop during a stall.
    go(3, 6);
    repeat (2) tick();
    stall = 1'b1; repeat (5) tick(); stall = 1'b0;
    repeat (20) tick();
    stall = 1'b1; tick();
    stop = 1'b1; tick();
    stop = 1'b0; stall = 1'b0;
    tick();

    // Random runs with stalls, writes, stray starts and occasional stops.
    for (int r = 0; r < 3; r++) begin
      go($urandom_range(0, 7), $urandom_range(0, 4));
      for (int c = 0; c < 150; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        stop  = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 9) == 0);
        cfg_if.cfg_we_i    = ($urandom_range(0, 7) == 0);
        cfg_if.cfg_addr_i  = CFG_ADDR_W'($urandom_range(0, (1 << CFG_ADDR_W) - 1));
        cfg_if.cfg_wdata_i = $urandom;
        n_ctx  = NCTX_W'($urandom_range(0, 7));
        period = 16'($urandom_range(0, 4));
        tick();
      end
      stall = 1'b0; start = 1'b0; cfg_if.cfg_we_i = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
    end

    // Reset in RUN clears everything including the store.
    go(2, 2);
    repeat (5) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
